// File: rtl/change_dispenser.sv
// Coin and ticket dispenser that sits behind the ticket vending FSM.
// It pulses the ticket solenoid, then pays change in 10s (falling back to 5s) and faults when change cannot be paid.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       change_in,
    input  logic             howrah,
    input  logic             manikaran,
    input  logic             esplanade,
    input  logic             empty10,
    input  logic             empty5,
    input  logic             clr_fault,
    output logic             tkt_fire,
    output logic [1:0]       tkt_sel,
    output logic             coin10_fire,
    output logic             coin5_fire,
    output logic             done,
    output logic [4:0]       residue,
    output logic             fault,
    output logic [4:0]       owed,
    output logic [CNT_W-1:0] cnt10,
    output logic [CNT_W-1:0] cnt5
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TICKET = 3'd1,
        S_TGAP   = 3'd2,
        S_EVAL   = 3'd3,
        S_FIRE   = 3'd4,
        S_GAP    = 3'd5,
        S_DONE   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Highest-priority destination wins when several ticket flags are set.
    function automatic logic [1:0] ticket_code(input logic e, input logic m, input logic h);
        logic [1:0] code;
        if (e) begin
            code = 2'b11;
        end else if (m) begin
            code = 2'b10;
        end else if (h) begin
            code = 2'b01;
        end else begin
            code = 2'b00;
        end
        return code;
    endfunction

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [4:0]       rem_q, rem_d;
    logic [1:0]       code_q, code_d;
    logic             sel10_q, sel10_d;
    logic             req_ready_q, req_ready_d;
    logic             tkt_fire_q, tkt_fire_d;
    logic [1:0]       tkt_sel_q, tkt_sel_d;
    logic             coin10_fire_q, coin10_fire_d;
    logic             coin5_fire_q, coin5_fire_d;
    logic             done_q, done_d;
    logic [4:0]       residue_q, residue_d;
    logic             fault_q, fault_d;
    logic [4:0]       owed_q, owed_d;
    logic [CNT_W-1:0] cnt10_q, cnt10_d;
    logic [CNT_W-1:0] cnt5_q, cnt5_d;

    // Next-state, datapath and next-output computation; outputs follow the next state so they are registered.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rem_d     = rem_q;
        code_d    = code_q;
        sel10_d   = sel10_q;
        residue_d = residue_q;
        owed_d    = owed_q;
        cnt10_d   = cnt10_q;
        cnt5_d    = cnt5_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rem_d     = change_in;
                    code_d    = ticket_code(esplanade, manikaran, howrah);
                    residue_d = 5'd0;
                    if (code_d != 2'b00) begin
                        state_d = S_TICKET;
                        timer_d = PULSE_LAST;
                    end else begin
                        state_d = S_EVAL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TICKET: begin
                if (timer_q == '0) begin
                    state_d = S_TGAP;
                    timer_d = GAP_LAST;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_TGAP, S_GAP: begin
                if (timer_q == '0) begin
                    state_d = S_EVAL;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_EVAL: begin
                if ((rem_q >= 5'd10) && !empty10) begin
                    state_d = S_FIRE;
                    timer_d = PULSE_LAST;
                    sel10_d = 1'b1;
                    rem_d   = rem_q - 5'd10;
                    cnt10_d = cnt10_q + CNT_W'(1);
                end else if ((rem_q >= 5'd5) && !empty5) begin
                    state_d = S_FIRE;
                    timer_d = PULSE_LAST;
                    sel10_d = 1'b0;
                    rem_d   = rem_q - 5'd5;
                    cnt5_d  = cnt5_q + CNT_W'(1);
                end else if (rem_q >= 5'd5) begin
                    state_d = S_FAULT;
                    owed_d  = rem_q;
                end else begin
                    state_d   = S_DONE;
                    residue_d = rem_q;
                end
            end
            S_FIRE: begin
                if (timer_q == '0) begin
                    state_d = S_GAP;
                    timer_d = GAP_LAST;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (clr_fault) begin
                    state_d = S_IDLE;
                    owed_d  = 5'd0;
                    rem_d   = 5'd0;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d   = (state_d == S_IDLE);
        tkt_fire_d    = (state_d == S_TICKET);
        tkt_sel_d     = tkt_fire_d ? code_d : 2'b00;
        coin10_fire_d = (state_d == S_FIRE) && sel10_d;
        coin5_fire_d  = (state_d == S_FIRE) && !sel10_d;
        done_d        = (state_d == S_DONE);
        fault_d       = (state_d == S_FAULT);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            rem_q         <= 5'd0;
            code_q        <= 2'b00;
            sel10_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            tkt_fire_q    <= 1'b0;
            tkt_sel_q     <= 2'b00;
            coin10_fire_q <= 1'b0;
            coin5_fire_q  <= 1'b0;
            done_q        <= 1'b0;
            residue_q     <= 5'd0;
            fault_q       <= 1'b0;
            owed_q        <= 5'd0;
            cnt10_q       <= '0;
            cnt5_q        <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            rem_q         <= rem_d;
            code_q        <= code_d;
            sel10_q       <= sel10_d;
            req_ready_q   <= req_ready_d;
            tkt_fire_q    <= tkt_fire_d;
            tkt_sel_q     <= tkt_sel_d;
            coin10_fire_q <= coin10_fire_d;
            coin5_fire_q  <= coin5_fire_d;
            done_q        <= done_d;
            residue_q     <= residue_d;
            fault_q       <= fault_d;
            owed_q        <= owed_d;
            cnt10_q       <= cnt10_d;
            cnt5_q        <= cnt5_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tkt_fire    = tkt_fire_q;
    assign tkt_sel     = tkt_sel_q;
    assign coin10_fire = coin10_fire_q;
    assign coin5_fire  = coin5_fire_q;
    assign done        = done_q;
    assign residue     = residue_q;
    assign fault       = fault_q;
    assign owed        = owed_q;
    assign cnt10       = cnt10_q;
    assign cnt5        = cnt5_q;

endmodule
